// File: rtl/transformer_pkg.sv
// Shared types for the transformer datapath plus the mha stream driver state set.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package transformer_pkg;

  localparam int SEQ    = 4;
  localparam int EMB    = 8;
  localparam int DATA_W = 16;

  typedef logic signed [DATA_W-1:0] elem_t;
  typedef elem_t [SEQ-1:0][EMB-1:0] seq_emb_t;

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } mha_drv_state_e;

  localparam int MHA_DRV_IDX_W = $clog2(SEQ * EMB);
  localparam int SEQ_W         = (SEQ > 1) ? $clog2(SEQ) : 1;
  localparam int EMB_W         = (EMB > 1) ? $clog2(EMB) : 1;

endpackage

// File: rtl/mha_seq_driver_seq_idx_ctr.sv
// Row-major (token, element) index counter for walking a seq_emb_t buffer.
// Latency: index updates the cycle after inc/clr; is_last/wrap are combinational.
// Backpressure: none; advances only when the owner asserts inc.
module seq_idx_ctr
  import transformer_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [SEQ_W-1:0] tok,
  output logic [EMB_W-1:0] elm,
  output logic             is_last,
  output logic             wrap
);

  assign is_last = (tok == SEQ_W'(SEQ - 1)) && (elm == EMB_W'(EMB - 1));
  assign wrap    = inc && is_last;

  // Step element first, then token; the final slot rolls back to (0,0).
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      tok <= '0;
      elm <= '0;
    end else if (inc) begin
      if (elm == EMB_W'(EMB - 1)) begin
        elm <= '0;
        tok <= (tok == SEQ_W'(SEQ - 1)) ? '0 : tok + 1'b1;
      end else begin
        elm <= elm + 1'b1;
      end
    end
  end

endmodule

// File: rtl/mha_seq_driver.sv
// Packs an element stream into one seq_emb_t, pulses mha, then replays mha's result as a stream.
// Latency: last input beat at cycle N -> mha_valid_in at N+1; result captured -> first m_valid next cycle.
// Backpressure: s_ready only in FILL; output holds m_data while m_ready is low. Optional macro MHA_DRV_TIMEOUT_EN.
module mha_seq_driver
  import transformer_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     s_valid,
  output logic     s_ready,
  input  elem_t    s_data,
  input  logic     s_last,
  output logic     mha_valid_in,
  output seq_emb_t mha_in_seq,
  input  logic     mha_valid_out,
  input  seq_emb_t mha_out_seq,
  output logic     m_valid,
  input  logic     m_ready,
  output elem_t    m_data,
  output logic     m_last,
  output logic     busy,
  output logic     err_len,
  output logic     err_stray,
  output logic     timeout
);

  mha_drv_state_e   state;
  seq_emb_t         in_buf;
  seq_emb_t         out_buf;

  logic [SEQ_W-1:0] fill_tok;
  logic [EMB_W-1:0] fill_elm;
  logic             fill_last;
  logic             fill_wrap;
  logic [SEQ_W-1:0] drain_tok;
  logic [EMB_W-1:0] drain_elm;
  logic             drain_last;
  logic             drain_wrap;

  logic s_fire;
  logic m_fire;
  logic early_last;

  assign s_fire     = s_valid && s_ready;
  assign m_fire     = m_valid && m_ready;
  assign early_last = s_fire && s_last && !fill_last;

  seq_idx_ctr u_fill_idx (
    .clk     (clk),
    .rst     (rst),
    .inc     (s_fire),
    .clr     (early_last),
    .tok     (fill_tok),
    .elm     (fill_elm),
    .is_last (fill_last),
    .wrap    (fill_wrap)
  );

  seq_idx_ctr u_drain_idx (
    .clk     (clk),
    .rst     (rst),
    .inc     (m_fire),
    .clr     (1'b0),
    .tok     (drain_tok),
    .elm     (drain_elm),
    .is_last (drain_last),
    .wrap    (drain_wrap)
  );

  assign mha_in_seq = in_buf;
  assign m_data     = out_buf[drain_tok][drain_elm];
  assign m_last     = m_valid && drain_last;
  assign busy       = (state != FILL) || (fill_tok != '0) || (fill_elm != '0);

  // Input buffer: write the accepted element; a short sequence zeroes every later slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_buf <= '0;
    end else if (s_fire) begin
      if (early_last) begin
        for (int t = 0; t < SEQ; t++) begin
          for (int e = 0; e < EMB; e++) begin
            if ((SEQ_W'(t) > fill_tok) ||
                ((SEQ_W'(t) == fill_tok) && (EMB_W'(e) > fill_elm))) begin
              in_buf[t][e] <= '0;
            end
          end
        end
      end
      in_buf[fill_tok][fill_elm] <= s_data;
    end
  end

  // Output buffer: only a result arriving while waiting is kept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_buf <= '0;
    end else if ((state == WAIT) && mha_valid_out) begin
      out_buf <= mha_out_seq;
    end
  end

`ifdef MHA_DRV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] wait_cnt;
`else
  assign timeout = 1'b0;
`endif

  // Sequencer FSM with registered handshake outputs and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= FILL;
      s_ready      <= 1'b1;
      mha_valid_in <= 1'b0;
      m_valid      <= 1'b0;
      err_len      <= 1'b0;
      err_stray    <= 1'b0;
`ifdef MHA_DRV_TIMEOUT_EN
      timeout      <= 1'b0;
      wait_cnt     <= '0;
`endif
    end else begin
      mha_valid_in <= 1'b0;
      if (mha_valid_out && (state != WAIT)) begin
        err_stray <= 1'b1;
      end
      case (state)
        FILL: begin
          if (fill_wrap || (s_fire && s_last)) begin
            if (fill_last != s_last) begin
              err_len <= 1'b1;
            end
            state        <= ISSUE;
            s_ready      <= 1'b0;
            mha_valid_in <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
`ifdef MHA_DRV_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: begin
          if (mha_valid_out) begin
            state   <= DRAIN;
            m_valid <= 1'b1;
          end
`ifdef MHA_DRV_TIMEOUT_EN
          else if (wait_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout <= 1'b1;
            state   <= FILL;
            s_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        DRAIN: begin
          if (drain_wrap) begin
            state   <= FILL;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
          end
        end
        default: begin
          state   <= FILL;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mha_seq_driver.sv
// Randomized self-checking bench for mha_seq_driver with an mha responder model.
// Latency: checks issue at last-beat+1 and drain order/stall hold against a flat array model.
// Backpressure: drives random input gaps and always/toggling/random m_ready.
module tb_mha_seq_driver;
  import transformer_pkg::*;

  localparam int N = SEQ * EMB;

  logic     clk = 1'b0;
  logic     rst;
  logic     s_valid;
  logic     s_ready;
  elem_t    s_data;
  logic     s_last;
  logic     mha_valid_in;
  seq_emb_t mha_in_seq;
  logic     mha_valid_out;
  seq_emb_t mha_out_seq;
  logic     m_valid;
  logic     m_ready;
  elem_t    m_data;
  logic     m_last;
  logic     busy;
  logic     err_len;
  logic     err_stray;
  logic     timeout;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  elem_t src[N];
  elem_t model_in[N];

  mha_seq_driver #(.TIMEOUT_CYC(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .mha_valid_in  (mha_valid_in),
    .mha_in_seq    (mha_in_seq),
    .mha_valid_out (mha_valid_out),
    .mha_out_seq   (mha_out_seq),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_last        (m_last),
    .busy          (busy),
    .err_len       (err_len),
    .err_stray     (err_stray),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
  endtask

  function automatic elem_t plus1(input elem_t v);
    return elem_t'(v + elem_t'(1));
  endfunction

  // One whole sequence: feed, expect one issue, optionally answer and drain.
  // rmode: 0 m_ready always, 1 toggling, 2 random. dmode: 0 (t+1)*(e+1), 1 random.
  task automatic do_seq(input int last_pos, input int rdelay, input int rmode,
                        input int dmode, input bit respond, input bit gaps);
    int    k        = 0;
    int    j        = 0;
    int    vin_cnt  = 0;
    int    last_cyc = -100;
    int    tmr      = 0;
    int    guard    = 0;
    bit    stalled  = 1'b0;
    bit    done     = 1'b0;
    elem_t held     = '0;
    for (int i = 0; i < N; i++) begin
      src[i]      = (dmode == 0) ? elem_t'((i / EMB + 1) * (i % EMB + 1)) : elem_t'($urandom);
      model_in[i] = (i <= last_pos) ? src[i] : elem_t'(0);
    end
    while (!done && guard < 3000) begin
      tick();
      guard++;
      if (mha_valid_in) begin
        vin_cnt++;
        if (vin_cnt == 1) begin
          chk("issue_latency", cyc, last_cyc + 1);
          for (int i = 0; i < N; i++)
            chk($sformatf("in_seq[%0d]", i), mha_in_seq[i / EMB][i % EMB], model_in[i]);
          tmr = rdelay;
          if (!respond) done = 1'b1;
        end
      end
      if (stalled) begin
        chk("stall_hold_data", m_data, held);
        chk("stall_hold_valid", m_valid, 1'b1);
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = '0;
      if (k <= last_pos && (!gaps || $urandom_range(3) != 0)) begin
        s_valid = 1'b1;
        s_data  = src[k];
        s_last  = (k == last_pos);
        if (s_ready) begin
          if (k == last_pos) last_cyc = cyc;
          k++;
        end
      end
      mha_valid_out = 1'b0;
      if (tmr > 0) begin
        tmr--;
        if (tmr == 0) begin
          mha_valid_out = 1'b1;
          for (int i = 0; i < N; i++) mha_out_seq[i / EMB][i % EMB] = plus1(model_in[i]);
        end
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = cyc[0];
        default: m_ready = 1'($urandom_range(1));
      endcase
      if (m_valid && m_ready) begin
        chk($sformatf("m_data[%0d]", j), m_data, plus1(model_in[j]));
        chk($sformatf("m_last[%0d]", j), m_last, (j == N - 1));
        j++;
        if (j == N) done = 1'b1;
      end
      stalled = m_valid && !m_ready;
      held    = m_data;
    end
    if (!done) chk("seq_cycle_budget", 0, 1);
    chk("issue_pulses", vin_cnt, 1);
    if (respond) begin
      tick();
      chk("s_ready_after_drain", s_ready, 1'b1);
      chk("m_valid_after_drain", m_valid, 1'b0);
    end
    s_valid       = 1'b0;
    s_last        = 1'b0;
    m_ready       = 1'b0;
    mha_valid_out = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    s_valid       = 1'b0;
    s_data        = '0;
    s_last        = 1'b0;
    mha_valid_out = 1'b0;
    mha_out_seq   = '0;
    m_ready       = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_valid_in", mha_valid_in, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err_len", err_len, 1'b0);
    chk("rst_err_stray", err_stray, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_in_seq", |mha_in_seq, 1'b0);
    rst = 1'b0;

    // Pattern sequence, 5-cycle responder, m_ready always high
    do_seq(N - 1, 5, 0, 0, 1'b1, 1'b0);
    chk("in_seq_3_7", mha_in_seq[3][7], elem_t'(32));
    chk("err_len_clean", err_len, 1'b0);
    chk("err_stray_clean", err_stray, 1'b0);

    // Random data with input gaps, toggling and then random m_ready
    do_seq(N - 1, 3, 1, 1, 1'b1, 1'b1);
    do_seq(N - 1, 7, 2, 1, 1'b1, 1'b1);
    chk("err_len_still_clean", err_len, 1'b0);

    // Short sequence: s_last on beat 9, zero-filled tail
    do_seq(9, 4, 0, 1, 1'b1, 1'b0);
    chk("err_len_short", err_len, 1'b1);

    // Stray result during FILL
    tick();
    mha_valid_out = 1'b1;
    for (int i = 0; i < N; i++) mha_out_seq[i / EMB][i % EMB] = elem_t'($urandom);
    tick();
    mha_valid_out = 1'b0;
    tick();
    chk("stray_flag", err_stray, 1'b1);
    chk("stray_s_ready", s_ready, 1'b1);
    chk("stray_busy", busy, 1'b0);
    chk("stray_m_valid", m_valid, 1'b0);
    for (int i = 0; i < N; i++)
      chk($sformatf("stray_in_seq[%0d]", i), mha_in_seq[i / EMB][i % EMB], model_in[i]);

    // Reset while waiting for mha
    do_seq(N - 1, 0, 0, 1, 1'b0, 1'b0);
    repeat (3) tick();
    chk("wait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_err_len", err_len, 1'b0);
    chk("mid_rst_err_stray", err_stray, 1'b0);
    chk("mid_rst_timeout", timeout, 1'b0);
    chk("mid_rst_s_ready", s_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_m_valid", m_valid, 1'b0);
    chk("mid_rst_in_seq", |mha_in_seq, 1'b0);

`ifdef MHA_DRV_TIMEOUT_EN
    // No response: abort after 16 WAIT cycles, nothing emitted
    do_seq(N - 1, 0, 0, 1, 1'b0, 1'b0);
    m_ready = 1'b1;
    for (int w = 1; w <= 16; w++) begin
      tick();
      chk($sformatf("to_wait_flag[%0d]", w), timeout, 1'b0);
      chk($sformatf("to_wait_ready[%0d]", w), s_ready, 1'b0);
      chk($sformatf("to_wait_mvalid[%0d]", w), m_valid, 1'b0);
    end
    tick();
    chk("to_flag", timeout, 1'b1);
    chk("to_s_ready", s_ready, 1'b1);
    chk("to_m_valid", m_valid, 1'b0);
    chk("to_busy", busy, 1'b0);
    m_ready       = 1'b0;
    mha_valid_out = 1'b1;
    tick();
    mha_valid_out = 1'b0;
    tick();
    chk("to_late_stray", err_stray, 1'b1);
    chk("to_late_m_valid", m_valid, 1'b0);
    do_seq(N - 1, 2, 0, 1, 1'b1, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
